// File: rtl/hi6110_bus_arbiter_if.sv
// rtl/hi6110_bus_arbiter_if.sv - requester and HI-6110 pin bundle for the bus arbiter
interface hi6110_bus_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  req_rw;
  logic [11:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic [15:0] rdata;
  logic        busy;
  logic [3:0]  reg_addr;
  logic [15:0] reg_data_o;
  logic        reg_data_oe;
  logic [15:0] reg_data_i;
  logic        cs;
  logic        rw;
  logic        str;

  modport master (
    output req, req_rw, req_addr, req_wdata, reg_data_i,
    input  grant, done, rdata, busy, reg_addr, reg_data_o, reg_data_oe, cs, rw, str
  );

  modport slave (
    input  req, req_rw, req_addr, req_wdata, reg_data_i,
    output grant, done, rdata, busy, reg_addr, reg_data_o, reg_data_oe, cs, rw, str
  );
endinterface

// File: rtl/hi6110_bus_arbiter.sv
// rtl/hi6110_bus_arbiter.sv - round-robin sharing of the HI-6110 register bus between three requesters
module hi6110_bus_arbiter #(
  parameter int T_SETUP = 5,
  parameter int T_STR   = 9,
  parameter int T_HOLD  = 7,
  parameter int T_GAP   = 6
) (
  input logic                 clk,
  input logic                 rst,
  hi6110_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP} state_t;

  localparam logic [4:0] L_SETUP = 5'(T_SETUP - 1);
  localparam logic [4:0] L_STR   = 5'(T_STR - 1);
  localparam logic [4:0] L_HOLD  = 5'(T_HOLD - 1);
  localparam logic [4:0] L_GAP   = 5'(T_GAP - 1);

  state_t      r_state, w_state;
  logic [4:0]  r_cnt, w_cnt;
  logic [1:0]  r_ptr, w_ptr;
  logic [1:0]  r_owner, w_owner;
  logic        r_read_op, w_read_op;
  logic [2:0]  r_grant, w_grant;
  logic [2:0]  r_done, w_done;
  logic [15:0] r_rdata, w_rdata;
  logic [15:0] r_capture, w_capture;
  logic        r_busy, w_busy;
  logic [3:0]  r_reg_addr, w_reg_addr;
  logic [15:0] r_reg_data_o, w_reg_data_o;
  logic        r_oe, w_oe;
  logic        r_cs, w_cs;
  logic        r_rw, w_rw;
  logic        r_str, w_str;

  logic        w_win_valid;
  logic [1:0]  w_win_idx;
  logic [3:0]  w_sel_addr;
  logic [15:0] w_sel_wdata;

  function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Scan from the pointer outward; the highest-offset hit is overwritten by nearer ones.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (bus.req[f_mod3_add(r_ptr, 2'(k))]) begin
        w_win_valid = 1'b1;
        w_win_idx   = f_mod3_add(r_ptr, 2'(k));
      end
    end
  end

  always_comb begin
    case (w_win_idx)
      2'd0:    begin w_sel_addr = bus.req_addr[3:0];  w_sel_wdata = bus.req_wdata[15:0];  end
      2'd1:    begin w_sel_addr = bus.req_addr[7:4];  w_sel_wdata = bus.req_wdata[31:16]; end
      default: begin w_sel_addr = bus.req_addr[11:8]; w_sel_wdata = bus.req_wdata[47:32]; end
    endcase
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_ptr        = r_ptr;
    w_owner      = r_owner;
    w_read_op    = r_read_op;
    w_grant      = 3'b000;
    w_done       = 3'b000;
    w_rdata      = r_rdata;
    w_capture    = r_capture;
    w_reg_addr   = r_reg_addr;
    w_reg_data_o = r_reg_data_o;
    w_oe         = r_oe;
    w_cs         = r_cs;
    w_rw         = r_rw;
    w_str        = r_str;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_state    = ST_SETUP;
          w_cnt      = L_SETUP;
          w_grant    = 3'(3'b001 << w_win_idx);
          w_owner    = w_win_idx;
          w_ptr      = f_mod3_add(w_win_idx, 2'd1);
          w_read_op  = bus.req_rw[w_win_idx];
          w_rw       = bus.req_rw[w_win_idx];
          w_reg_addr = w_sel_addr;
          w_cs       = 1'b0;
          w_oe       = ~bus.req_rw[w_win_idx];
          if (!bus.req_rw[w_win_idx]) w_reg_data_o = w_sel_wdata;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 5'd0) begin
          w_state = ST_STROBE;
          w_cnt   = L_STR;
          w_str   = 1'b0;
        end else begin
          w_cnt = r_cnt - 5'd1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == 5'd0) begin
          w_state   = ST_HOLD;
          w_cnt     = L_HOLD;
          w_str     = 1'b1;
          w_capture = bus.reg_data_i;
        end else begin
          w_cnt = r_cnt - 5'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 5'd0) begin
          w_state = ST_GAP;
          w_cnt   = L_GAP;
          w_cs    = 1'b1;
          w_rw    = 1'b1;
          w_oe    = 1'b0;
        end else begin
          w_cnt = r_cnt - 5'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 5'd0) begin
          w_state = ST_IDLE;
          w_done  = 3'(3'b001 << r_owner);
          if (r_read_op) w_rdata = r_capture;
        end else begin
          w_cnt = r_cnt - 5'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 5'd0;
      r_ptr        <= 2'd0;
      r_owner      <= 2'd0;
      r_read_op    <= 1'b0;
      r_grant      <= 3'b000;
      r_done       <= 3'b000;
      r_rdata      <= 16'h0000;
      r_capture    <= 16'h0000;
      r_busy       <= 1'b0;
      r_reg_addr   <= 4'h0;
      r_reg_data_o <= 16'h0000;
      r_oe         <= 1'b0;
      r_cs         <= 1'b1;
      r_rw         <= 1'b1;
      r_str        <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_ptr        <= w_ptr;
      r_owner      <= w_owner;
      r_read_op    <= w_read_op;
      r_grant      <= w_grant;
      r_done       <= w_done;
      r_rdata      <= w_rdata;
      r_capture    <= w_capture;
      r_busy       <= w_busy;
      r_reg_addr   <= w_reg_addr;
      r_reg_data_o <= w_reg_data_o;
      r_oe         <= w_oe;
      r_cs         <= w_cs;
      r_rw         <= w_rw;
      r_str        <= w_str;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.done        = r_done;
  assign bus.rdata       = r_rdata;
  assign bus.busy        = r_busy;
  assign bus.reg_addr    = r_reg_addr;
  assign bus.reg_data_o  = r_reg_data_o;
  assign bus.reg_data_oe = r_oe;
  assign bus.cs          = r_cs;
  assign bus.rw          = r_rw;
  assign bus.str         = r_str;

endmodule
